pipeline_hazard_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, hazard FSM states and the load-use hazard equation
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HALTED
    } state_t;

    // A load in EX whose destination feeds an ID source must be separated by a bubble;
    // register 0 never carries a real dependency.
    function automatic logic load_use_hazard(
        input logic     mem_to_reg,
        input regbits_t wsel,
        input regbits_t rs,
        input regbits_t rt,
        input logic     uses_rt
    );
        return mem_to_reg && (wsel != '0) && ((wsel == rs) || (uses_rt && (wsel == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at its maximum value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear dominates; increments stop once all ones is reached
    always_comb begin
        cnt_d = clr ? '0 : (inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with halt tracking and statistics
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req_MEM,
    input  logic             redirect_MEM,
    input  logic             memtoReg_EX,
    input  logic [4:0]       wsel_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rt_ID,
    input  logic             halt_WB,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t state_q;
    state_t state_d;
    logic   frozen;
    logic   mem_wait;
    logic   load_use;
    logic   stall_inc;
    logic   flush_inc;

    assign frozen   = (state_q == HALTED) || halt_WB;
    assign mem_wait = dmem_req_MEM && !dhit;
    assign load_use = load_use_hazard(memtoReg_EX, wsel_EX, rs_ID, rt_ID, uses_rt_ID);

    // First matching hazard decides every register control; the FSM only tracks wait/halt
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        if (!nRST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (frozen) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (redirect_MEM) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
        if (frozen) begin
            state_d = HALTED;
        end else if (mem_wait) begin
            state_d = MEM_WAIT;
        end else if ((state_q == MEM_WAIT) && dhit) begin
            state_d = RUN;
        end
    end

    // FSM state register; only reset leaves HALTED
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted    = (state_q == HALTED);
    assign stall_inc = nRST && !pc_en && (state_q != HALTED) && !halt_WB;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .clr (!nRST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (CLK),
        .clr (!nRST),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus checked against a rule-level model every cycle
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, dmem_req_MEM, redirect_MEM, memtoReg_EX, uses_rt_ID, halt_WB;
    logic [4:0] wsel_EX, rs_ID, rt_ID;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
    logic        s_exmem_en, s_exmem_flush, s_memwb_en, s_memwb_flush, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req_MEM(dmem_req_MEM),
        .redirect_MEM(redirect_MEM), .memtoReg_EX(memtoReg_EX), .wsel_EX(wsel_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .halt_WB(halt_WB),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req_MEM(dmem_req_MEM),
        .redirect_MEM(redirect_MEM), .memtoReg_EX(memtoReg_EX), .wsel_EX(wsel_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .halt_WB(halt_WB),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
        .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush),
        .memwb_en(s_memwb_en), .memwb_flush(s_memwb_flush), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Packed as {pc, ifid en/flush, idex en/flush, exmem en/flush, memwb en/flush}
    logic [8:0] dut_v, sat_v;
    assign dut_v = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush};
    assign sat_v = {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_exmem_flush, s_memwb_en, s_memwb_flush};

    localparam logic [8:0] V_RST    = 9'b0_01_01_01_01;
    localparam logic [8:0] V_FROZEN = 9'b0_00_00_00_00;
    localparam logic [8:0] V_MWAIT  = 9'b0_00_00_00_11;
    localparam logic [8:0] V_REDIR  = 9'b1_11_11_11_10;
    localparam logic [8:0] V_LU     = 9'b0_00_11_10_10;
    localparam logic [8:0] V_IMISS  = 9'b0_11_10_10_10;
    localparam logic [8:0] V_RUN    = 9'b1_10_10_10_10;

    logic m_halted = 1'b0;
    int   m_stall  = 0;
    int   m_flush  = 0;
    logic armed    = 1'b0;

    function automatic logic [8:0] model_v(input logic h);
        if (!nRST) return V_RST;
        if (h || halt_WB) return V_FROZEN;
        if (dmem_req_MEM && !dhit) return V_MWAIT;
        if (redirect_MEM) return V_REDIR;
        if (memtoReg_EX && wsel_EX != 5'd0 && (wsel_EX == rs_ID || (uses_rt_ID && wsel_EX == rt_ID))) return V_LU;
        if (!ihit) return V_IMISS;
        return V_RUN;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state advances with the clock from the rules applied to this cycle's inputs
    always @(posedge CLK) begin
        logic [8:0] v;
        v = model_v(m_halted);
        if (!nRST) begin
            m_halted = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
        end else if (!m_halted) begin
            if (halt_WB) m_halted = 1'b1;
            else begin
                if (!v[8]) m_stall++;
                if (v == V_REDIR) m_flush++;
            end
        end
        armed = 1'b1;
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge CLK) begin
        if (armed) begin
            chk("ctrl", int'(dut_v), int'(model_v(m_halted)));
            chk("ctrl_sat", int'(sat_v), int'(model_v(m_halted)));
            chk("halted", int'(halted), int'(m_halted));
            chk("stall_cnt", int'(stall_cnt), sat(m_stall, 65535));
            chk("flush_cnt", int'(flush_cnt), sat(m_flush, 65535));
            chk("stall_cnt_sat", int'(s_stall_cnt), sat(m_stall, 15));
            chk("flush_cnt_sat", int'(s_flush_cnt), sat(m_flush, 15));
        end
    end

    task automatic idle();
        nRST = 1'b1; ihit = 1'b1; dhit = 1'b0; dmem_req_MEM = 1'b0; redirect_MEM = 1'b0;
        memtoReg_EX = 1'b0; uses_rt_ID = 1'b0; halt_WB = 1'b0;
        wsel_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
    endtask

    task automatic to_neg();
        @(negedge CLK);
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        to_neg(); chk("L_rst_v", int'(dut_v), int'(V_RST)); next();
        to_neg(); chk("L_rst_cnt", int'(stall_cnt), 0); next();
        nRST = 1'b1;
        to_neg(); chk("L_run_v", int'(dut_v), int'(V_RUN)); next();
        memtoReg_EX = 1'b1; wsel_EX = 5'd8; rs_ID = 5'd8;
        to_neg(); chk("L_lu_v", int'(dut_v), int'(V_LU)); next();
        wsel_EX = 5'd0; rs_ID = 5'd0;
        to_neg(); chk("L_lu0_v", int'(dut_v), int'(V_RUN)); chk("L_lu_cnt", int'(stall_cnt), 1); next();
        wsel_EX = 5'd8; rs_ID = 5'd3; rt_ID = 5'd8; uses_rt_ID = 1'b1;
        to_neg(); chk("L_lurt_v", int'(dut_v), int'(V_LU)); next();
        uses_rt_ID = 1'b0;
        to_neg(); chk("L_lunort_v", int'(dut_v), int'(V_RUN)); next();
        idle();
        dmem_req_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg(); chk("L_mw_v", int'(dut_v), int'(V_MWAIT)); next();
        end
        dhit = 1'b1;
        to_neg(); chk("L_mwdone_v", int'(dut_v), int'(V_RUN)); chk("L_mw_cnt", int'(stall_cnt), 5); next();
        dhit = 1'b0; redirect_MEM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            to_neg(); chk("L_mwr_v", int'(dut_v), int'(V_MWAIT)); next();
        end
        dhit = 1'b1;
        to_neg(); chk("L_redir_v", int'(dut_v), int'(V_REDIR)); chk("L_redir_fc0", int'(flush_cnt), 0); next();
        idle(); ihit = 1'b0;
        to_neg(); chk("L_imiss_v", int'(dut_v), int'(V_IMISS)); chk("L_redir_fc1", int'(flush_cnt), 1);
        chk("L_redir_sc", int'(stall_cnt), 7); next();
        for (int i = 0; i < 20; i++) next();
        memtoReg_EX = 1'b1; wsel_EX = 5'd4; rs_ID = 5'd4;
        to_neg(); chk("L_lu_imiss_v", int'(dut_v), int'(V_LU)); chk("L_sc28", int'(stall_cnt), 28);
        chk("L_sat15", int'(s_stall_cnt), 15); next();
        idle(); halt_WB = 1'b1;
        to_neg(); chk("L_halt_v", int'(dut_v), int'(V_FROZEN)); chk("L_halt_h0", int'(halted), 0); next();
        halt_WB = 1'b0; redirect_MEM = 1'b1; ihit = 1'b0; dmem_req_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg(); chk("L_frozen_v", int'(dut_v), int'(V_FROZEN)); chk("L_frozen_h", int'(halted), 1); next();
        end
        dhit = 1'b1; memtoReg_EX = 1'b1; wsel_EX = 5'd2; rs_ID = 5'd2;
        to_neg(); chk("L_frozen_sc", int'(stall_cnt), 29); chk("L_frozen_fc", int'(flush_cnt), 1); next();
        nRST = 1'b0;
        to_neg(); chk("L_rst2_v", int'(dut_v), int'(V_RST)); next();
        idle();
        to_neg(); chk("L_rst2_h", int'(halted), 0); chk("L_rst2_sc", int'(stall_cnt), 0); next();
        dmem_req_MEM = 1'b1;
        next();
        nRST = 1'b0;
        next();
        idle();
        to_neg(); chk("L_rstmw_v", int'(dut_v), int'(V_RUN)); next();
        dhit = 1'b0;
        to_neg(); chk("L_rstmw_sc", int'(stall_cnt), 0); next();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
